// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU issuer: FSM state encoding and the FIFO entry
// that carries one instruction word together with its two source operands.
package fir_xifu_pkg;

    typedef enum logic {
        ISSUE  = 1'b0,
        COMMIT = 1'b1
    } fir_xifu_issuer_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } fir_xifu_issue_entry_t;

    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/cv32e40x_if_xif.sv
// Reduced CV-X-IF bundle: only the issue and commit channels that the FIR
// issuer and coprocessor exchange, with two register-file read ports.
interface cv32e40x_if_xif #(
    parameter int unsigned X_ID_WIDTH = 4
);

    typedef struct packed {
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [1:0][31:0]      rs;
        logic [1:0]            rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic loadstore;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    logic          issue_valid;
    logic          issue_ready;
    x_issue_req_t  issue_req;
    x_issue_resp_t issue_resp;
    logic          commit_valid;
    x_commit_t     commit;

    modport cpu_issue (
        output issue_valid,
        input  issue_ready,
        output issue_req,
        input  issue_resp
    );

    modport coproc_issue (
        input  issue_valid,
        output issue_ready,
        input  issue_req,
        output issue_resp
    );

    modport cpu_commit (
        output commit_valid,
        output commit
    );

    modport coproc_commit (
        input commit_valid,
        input commit
    );

endinterface

// File: rtl/fir_xifu_issue_fifo.sv
// Synchronous first-word-fall-through FIFO of issue entries; the head entry is
// visible combinationally whenever the FIFO is not empty.
module fir_xifu_issue_fifo
    import fir_xifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  fir_xifu_issue_entry_t data_i,
    input  logic                  pop_i,
    output fir_xifu_issue_entry_t head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    fir_xifu_issue_entry_t mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fir_xifu_issuer.sv
// Core-side CV-X-IF initiator: queues instructions, issues them to the FIR
// XIFU and commits or kills each one. Define FIR_XIFU_ISSUER_STATS_EN for stats.
module fir_xifu_issuer
    import fir_xifu_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [31:0]           rs1_i,
    input  logic [31:0]           rs2_i,
    cv32e40x_if_xif.cpu_issue     xif_issue_o,
    cv32e40x_if_xif.cpu_commit    xif_commit_o,
    output logic                  resp_valid_o,
    output logic                  resp_accept_o,
    output logic                  resp_writeback_o,
    output logic                  resp_loadstore_o,
    output logic [X_ID_WIDTH-1:0] resp_id_o,
    output logic                  busy_o
`ifdef FIR_XIFU_ISSUER_STATS_EN
    ,
    output logic [STAT_W-1:0]     n_accept_o,
    output logic [STAT_W-1:0]     n_reject_o
`endif
);

    fir_xifu_issuer_state_e state_q, state_d;
    logic [X_ID_WIDTH-1:0]  id_q, id_d;
    logic                   accept_q, accept_d;
    logic                   writeback_q, writeback_d;
    logic                   loadstore_q, loadstore_d;

    fir_xifu_issue_entry_t  push_entry;
    fir_xifu_issue_entry_t  head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   issue_valid;
    logic                   handshake;
    logic                   in_commit;

    assign push_entry    = '{instr: instr_i, rs1: rs1_i, rs2: rs2_i};
    assign instr_ready_o = ~fifo_full;
    assign push          = instr_valid_i & ~fifo_full;
    assign in_commit     = (state_q == COMMIT);
    // Head stays put until the handshake pops it, so issue_req cannot change
    // while issue_valid is waiting for ready.
    assign issue_valid   = (state_q == ISSUE) & ~fifo_empty;
    assign handshake     = issue_valid & xif_issue_o.issue_ready;

    fir_xifu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (handshake),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        accept_d    = accept_q;
        writeback_d = writeback_q;
        loadstore_d = loadstore_q;
        unique case (state_q)
            ISSUE: begin
                if (handshake) begin
                    state_d     = COMMIT;
                    accept_d    = xif_issue_o.issue_resp.accept;
                    writeback_d = xif_issue_o.issue_resp.writeback;
                    loadstore_d = xif_issue_o.issue_resp.loadstore;
                end
            end
            COMMIT: begin
                state_d = ISSUE;
                id_d    = id_q + X_ID_WIDTH'(1);
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ISSUE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // Captured response fields are only observed in COMMIT, so they need no reset.
    always_ff @(posedge clk_i) begin
        accept_q    <= accept_d;
        writeback_q <= writeback_d;
        loadstore_q <= loadstore_d;
    end

    always_comb begin
        xif_issue_o.issue_valid = issue_valid;
        xif_issue_o.issue_req   = '0;
        if (issue_valid) begin
            xif_issue_o.issue_req.instr    = head.instr;
            xif_issue_o.issue_req.id       = id_q;
            xif_issue_o.issue_req.rs[0]    = head.rs1;
            xif_issue_o.issue_req.rs[1]    = head.rs2;
            xif_issue_o.issue_req.rs_valid = '1;
        end
    end

    always_comb begin
        xif_commit_o.commit_valid = in_commit;
        xif_commit_o.commit       = '0;
        if (in_commit) begin
            xif_commit_o.commit.id          = id_q;
            xif_commit_o.commit.commit_kill = ~accept_q;
        end
    end

    always_comb begin
        resp_valid_o     = in_commit;
        resp_accept_o    = in_commit & accept_q;
        resp_writeback_o = in_commit & writeback_q;
        resp_loadstore_o = in_commit & loadstore_q;
        resp_id_o        = in_commit ? id_q : '0;
        busy_o           = ~fifo_empty | in_commit;
    end

`ifdef FIR_XIFU_ISSUER_STATS_EN
    logic [STAT_W-1:0] n_accept_q, n_accept_d;
    logic [STAT_W-1:0] n_reject_q, n_reject_d;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

    always_comb begin
        n_accept_d = n_accept_q;
        n_reject_d = n_reject_q;
        if (in_commit) begin
            if (accept_q) begin
                n_accept_d = sat_inc(n_accept_q);
            end else begin
                n_reject_d = sat_inc(n_reject_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_accept_q <= '0;
            n_reject_q <= '0;
        end else begin
            n_accept_q <= n_accept_d;
            n_reject_q <= n_reject_d;
        end
    end

    assign n_accept_o = n_accept_q;
    assign n_reject_o = n_reject_q;
`endif

endmodule

// File: doc/fir_xifu_issuer.md
# fir_xifu_issuer

Core-side initiator of the CV-X-IF issue and commit interfaces: it feeds instructions to the FIR XIFU coprocessor and commits or kills each one after the coprocessor responds. It buffers instruction words and source operands in a small FIFO, drives `issue_valid`/`issue_req` with a hold-until-ready handshake, captures `issue_resp`, then emits exactly one commit per offloaded instruction. It sits between the standalone FIR test/integration harness and the XIFU decode stage, standing in for the offloading core.

## Interface
Parameters:
- `DEPTH`, 4: instruction FIFO entries; a power of two, at least 2.
- `X_ID_WIDTH`, 4: width of the transaction ID; must match the `cv32e40x_if_xif` instance.

Ports (reset is synchronous and active-high, one clock):
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `instr_valid_i`  in  1  feeder has an instruction
- `instr_ready_o`  out  1  FIFO not full
- `instr_i`  in  32  instruction word
- `rs1_i`  in  32  operand rs[0]
- `rs2_i`  in  32  operand rs[1]
- `xif_issue_o`  modport  `cv32e40x_if_xif.cpu_issue`  issue channel
- `xif_commit_o`  modport  `cv32e40x_if_xif.cpu_commit`  commit channel
- `resp_valid_o`  out  1  one-cycle pulse per completed issue
- `resp_accept_o`, `resp_writeback_o`, `resp_loadstore_o`  out  1 each  captured `issue_resp` fields
- `resp_id_o`  out  `X_ID_WIDTH`  ID of the reported instruction
- `busy_o`  out  1  FIFO non-empty or state is COMMIT
- `n_accept_o`, `n_reject_o`  out  16 each  statistics counters (only with `FIR_XIFU_ISSUER_STATS_EN`)

## Operation
- FIFO push on `instr_valid_i & instr_ready_o`; `instr_ready_o = ~full`. When the FIFO is full, a pop in the same cycle does not enable a push.
- FSM has two states, ISSUE (reset state) and COMMIT.
- ISSUE: `issue_valid = ~empty`; `issue_req.instr`/`rs[0]`/`rs[1]` come from the FIFO head; `issue_req.id = id_q`; `rs_valid` is all ones.
- Once `issue_valid` is raised, it and `issue_req` stay stable until `issue_ready` is sampled high. No retraction.
- Handshake (`issue_valid & issue_ready`) captures the `accept`, `writeback` and `loadstore` fields of `issue_resp`, pops the FIFO, and moves the FSM to COMMIT.
- COMMIT lasts exactly one cycle:
  - `commit_valid = 1`, `commit.id = id_q`, `commit_kill = ~accept_q`.
  - `resp_valid_o = 1` with the captured fields and `resp_id_o = id_q`.
  - `id_q` increments modulo 2^`X_ID_WIDTH` (wraps 15→0 at the default width).
  - The FSM returns to ISSUE.
- Rejected instructions (`accept = 0`) are still committed, with kill asserted. No retry.
- Outside these conditions every `issue_req`/`commit` field drives `'0`.

## Timing
- Reset values: `instr_ready_o = 1`, `issue_valid = 0`, `commit_valid = 0`, `resp_*_o = 0`, `busy_o = 0`, `id_q = 0`, counters = 0, FSM = ISSUE, FIFO empty.
- Push at edge k makes `issue_valid` high in the cycle after edge k (1-cycle latency to issue).
- Handshake at edge m puts commit and `resp_valid_o` in the cycle after m. The next issue is possible at the earliest one cycle after that, so peak throughput is 1 instruction per 2 cycles.
- `issue_ready` low for N cycles: the request is held for N+1 cycles, with unchanged ID and data.
- Reset asserted mid-transaction clears the FIFO, FSM, ID and counters on that edge. The in-flight instruction gets no commit.

## Configuration
- `FIR_XIFU_ISSUER_STATS_EN` defined:
  - `n_accept_o`/`n_reject_o` increment in COMMIT according to `accept_q`.
  - They saturate at 16'hFFFF and clear on reset.
- Not defined: both ports are absent and no counter flops are synthesised.

## Structure
- `fir_xifu_pkg` gains:
  - `fir_xifu_issuer_state_e` (ISSUE, COMMIT);
  - `fir_xifu_issue_entry_t` (instr, rs1, rs2: 96 bits).
- Sub-module `fir_xifu_issue_fifo`: synchronous FIFO of `fir_xifu_issue_entry_t` with push, pop, full, empty and a first-word-fall-through head. The FSM, ID counter and stats stay in the top level.

## Test plan
- Single XFIRDOTP word, coprocessor `issue_ready = 1`, `accept = 1` → `issue_valid` 1 cycle after push. One cycle later: `commit_valid = 1`, `commit_kill = 0`, `resp_id_o = 0`, `resp_writeback_o = 0`.
- Back-pressure: `issue_ready` low for 3 cycles → `issue_req` held stable for 4 cycles with `id = 0`, then committed once.
- Fill the FIFO with 5 pushes while `issue_ready = 0` → `instr_ready_o` drops after 4 pushes and the 5th is not accepted. Releasing ready then drains all 4 with IDs 0..3.
- Unknown funct3 (`accept = 0`) → `commit_kill = 1`, `resp_accept_o = 0`; with STATS_EN, `n_reject_o = 1`.
- 17 back-to-back instructions → `resp_id_o` sequence 0..15, 0, confirming the wrap.
- Assert `rst_i` on the handshake cycle → no commit follows, `busy_o = 0`, and the next issue uses `id = 0`.
